// File: rtl/in_data_packer.sv
// Packs DSIZE-bit pixels from the aligned video input stream into MSIZE-bit VDMA FIFO words tagged with eol/eof.
// Latency: a word is written 1 cycle after the pixel that fills or flushes it; frame_start 1 cycle after falign.
// Backpressure: none upstream (1 pixel/cycle); a word offered while fifo_full=1 is dropped and flagged in overflow.
//
// Ports:
//   clock, rst_n               block clock, synchronous active-low reset
//   falign/lalign/ealign       frame start / line end / frame end markers (one-cycle pulses)
//   idata_vld, idata           pixel stream
//   fifo_full                  write FIFO cannot take a word this cycle
//   clr_err                    clears the sticky error flags
//   wr_en, wr_data             FIFO write strobe and packed word (slot 0 in the LSBs)
//   wr_eol, wr_eof             word holds a line end / the frame end (valid with wr_en)
//   frame_start                registered pulse after each falign
//   overflow, sync_err         sticky error flags
module in_data_packer #(
  parameter int DSIZE = 24,
  parameter int MSIZE = 128,
  parameter     MODE  = "ONCE"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             falign,
  input  logic             lalign,
  input  logic             ealign,
  input  logic             idata_vld,
  input  logic [DSIZE-1:0] idata,
  input  logic             fifo_full,
  input  logic             clr_err,
  output logic             wr_en,
  output logic [MSIZE-1:0] wr_data,
  output logic             wr_eol,
  output logic             wr_eof,
  output logic             frame_start,
  output logic             overflow,
  output logic             sync_err
);

  localparam int NUM       = MSIZE / DSIZE;
  localparam int CW        = $clog2(NUM) + 1;
  localparam int PW        = NUM * DSIZE;
  localparam bit LINE_MODE = (MODE == "LINE");

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;       // next free slot in the word being built
  logic [PW-1:0] sreg;      // pixels collected so far, slot k at [k*DSIZE]
  logic          eol_pend;  // a line already ended inside the word being built

  logic [CW-1:0]    slot;
  logic [PW-1:0]    merged;
  logic [MSIZE-1:0] word;
  logic             take;
  logic             flush;
  logic             line_end;
  logic             sync_evt;
  logic             ovf_evt;

  // falign restarts the word in the same cycle, so a pixel arriving with it
  // lands in slot 0 of a fresh word and any partial word is simply dropped.
  always_comb begin
    slot   = falign ? '0 : cnt;
    merged = falign ? '0 : sreg;
    for (int k = 0; k < NUM; k++) begin
      if (slot == CW'(k)) merged[k*DSIZE +: DSIZE] = idata;
    end
    word          = '0;
    word[PW-1:0]  = merged;
    take          = idata_vld && (falign || state == ACTIVE);
    line_end      = lalign || (!falign && eol_pend);
    // A word that fills exactly on a line/frame end is one flush, not two.
    flush         = (slot == CW'(NUM - 1)) || (LINE_MODE && lalign) || ealign;
    sync_evt      = falign ? (state == ACTIVE) : (state == IDLE && idata_vld);
    ovf_evt       = take && flush && fifo_full;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      eol_pend    <= 1'b0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      wr_eol      <= 1'b0;
      wr_eof      <= 1'b0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= falign;
      // A same-cycle error event outranks clr_err.
      overflow    <= (overflow && !clr_err) || ovf_evt;
      sync_err    <= (sync_err && !clr_err) || sync_evt;

      if (falign) begin
        state    <= ACTIVE;
        cnt      <= '0;
        sreg     <= '0;
        eol_pend <= 1'b0;
      end

      if (take) begin
        if (flush) begin
          if (!fifo_full) begin
            wr_en   <= 1'b1;
            wr_data <= word;
            wr_eol  <= line_end;
            wr_eof  <= ealign;
          end
          cnt      <= '0;
          sreg     <= '0;
          eol_pend <= 1'b0;
          if (ealign) state <= IDLE;
        end else begin
          sreg     <= merged;
          cnt      <= slot + CW'(1);
          eol_pend <= line_end;
        end
      end
    end
  end

endmodule

// File: doc/in_data_packer.md
Name: in_data_packer

Overview:
- Stage directly downstream of the video input port.
- Consumes its aligned pixel stream (odata_vld/odata plus the falign/lalign/ealign frame markers) and packs DSIZE-bit pixels into MSIZE-bit memory words for the VDMA write FIFO.
- Tags each word with end-of-line and end-of-frame flags.
- Flushes partial words at line or frame boundaries.
- Reports FIFO overflow and frame-sync errors.

Parameters:
- DSIZE, 24, pixel width in bits.
- MSIZE, 128, memory word width in bits. NUM = MSIZE/DSIZE (integer division, NUM>=1) pixels per word; upper MSIZE-NUM*DSIZE bits are zero.
- MODE, "ONCE", "LINE": flush a partial word at every line end. "ONCE": flush only at frame end, so words span lines.

Ports:
- clock  in  1  block clock
- rst_n  in  1  reset, synchronous, active-low
- falign  in  1  one-cycle pulse, frame start; may coincide with the first pixel
- lalign  in  1  one-cycle pulse, coincides with the last pixel of a line (odata_vld=1)
- ealign  in  1  one-cycle pulse, coincides with the last pixel of a frame (lalign also 1)
- idata_vld  in  1  pixel valid
- idata  in  DSIZE  pixel
- fifo_full  in  1  write FIFO cannot accept a word this cycle
- clr_err  in  1  clears sticky error flags
- wr_en  out  1  FIFO write strobe
- wr_data  out  MSIZE  packed word
- wr_eol  out  1  word contains the last pixel of a line (valid with wr_en)
- wr_eof  out  1  word contains the last pixel of a frame (valid with wr_en)
- frame_start  out  1  one-cycle pulse, registered, one cycle after accepted falign
- overflow  out  1  sticky: a word was dropped because fifo_full=1
- sync_err  out  1  sticky: falign arrived mid-frame, or a pixel arrived in IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs are 0.
  - State = IDLE; pixel slot index = 0; shift register cleared.
  - Reset mid-frame discards the partial word with no write.
- States:
  - IDLE: ignores pixels; if idata_vld=1 without falign, sets sync_err. falign moves to ACTIVE.
  - ACTIVE: packs pixels. ealign causes the final flush and returns to IDLE.
- falign together with idata_vld: that pixel is packed as slot 0 of the new frame.
- falign while ACTIVE:
  - The partial word is discarded and sync_err is set.
  - The slot index resets to 0; the state stays ACTIVE.
  - frame_start pulses.
- Packing:
  - Pixel at slot k occupies wr_data[k*DSIZE +: DSIZE]; slot 0 is the first pixel in time.
  - Unfilled slots and padding bits are 0.
- Word emission:
  - Triggered by the pixel filling slot NUM-1, by lalign (MODE "LINE"), or by ealign (any MODE).
  - wr_en is asserted exactly 1 cycle after the triggering pixel; wr_data, wr_eol, wr_eof are registered alongside it.
  - Slot index returns to 0.
  - A word that fills exactly at a flush point emits once, not twice.
- MODE "ONCE": lalign does not flush.
  - wr_eol=1 on the word holding the line's last pixel, including when that word is emitted later.
  - If a word holds several line ends, wr_eol=1 once.
- wr_eof=1 only on the word holding the ealign pixel; wr_eol is also 1 on it.
- Throughput: one pixel per cycle sustained, no back-pressure upstream.
- FIFO full:
  - If fifo_full=1 in the cycle wr_en would assert, the word is dropped: wr_en=0, overflow set.
  - Packing continues unaffected.
- clr_err=1 clears overflow and sync_err next cycle. An error event in the same cycle wins, so the flag stays 1.
- Slot counter is $clog2(NUM)+1 bits; it never exceeds NUM-1.

Test Plan:
1. DSIZE=24, MSIZE=128 (NUM=5), MODE "LINE"; one frame of 2 lines × 12 pixels with values 1..24, fifo_full=0.
   - Expect 6 words: pixels {1-5}, {6-10}, {11,12} with wr_eol, {13-17}, {18-22}, {23,24} with wr_eol and wr_eof.
   - Word 3 equals 0x...000C_00000B, upper bits zero.
   - Each wr_en comes 1 cycle after its trigger pixel; frame_start pulses once.
2. Same stimulus with MODE "ONCE".
   - Expect 5 words: {1-5}, {6-10}, {11-15} with wr_eol, {16-20}, {21-24} with wr_eol and wr_eof.
3. Line length 10 in MODE "LINE": the line end coincides with a full word.
   - Exactly 2 words per line; the second has wr_eol; no empty flush word.
4. fifo_full=1 during the cycle the 2nd word would be written.
   - That word is missing and overflow=1.
   - Subsequent words are correct.
   - clr_err clears overflow the next cycle.
5. falign after 3 pixels of an ACTIVE frame.
   - No write of the 3 pixels; sync_err=1; frame_start pulses.
   - The next word starts with the pixel accompanying or following falign.
6. rst_n=0 for 1 cycle mid-word, then a pixel without falign.
   - All outputs 0 after reset and no write.
   - The pixel in IDLE sets sync_err.
